pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard-detection and operand-forwarding controller for the five-stage (IF/ID/EX/MEM/WB) pipeline. It sits beside the pipeline registers and tracks the destination metadata of every in-flight instruction. From that it drives a per-operand forwarding mux into EX, a load-use stall, and branch flushes. It generalises the current fixed two-operand, 5-bit, 32-bit scheme to N source operands, arbitrary data/register-address widths and an optional hardwired zero register.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-address width
- NUM_SRC, 2, source operands per instruction (1..4)
- R0_ZERO, 1, when 1 destination address 0 is never forwarded nor stalled on

Ports (clock and reset first):
- clc  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_src_addr  input  NUM_SRC*REG_AW  ID source register addresses, operand k at [k*REG_AW +: REG_AW]
- id_src_used  input  NUM_SRC  operand k actually read by the ID instruction
- id_dst_addr  input  REG_AW  ID destination register
- id_dst_we  input  1  ID instruction writes the register file
- id_is_load  input  1  ID instruction is a load (data available in WB only)
- ex_branch_taken  input  1  EX-stage branch/jump resolved taken
- ex_rf_data  input  NUM_SRC*DATA_W  register-file values latched into ID/EX
- mem_alu_data  input  DATA_W  EX/MEM ALU result
- wb_data  input  DATA_W  MEM/WB write-back data (ALU or load)
- ex_opnd  output  NUM_SRC*DATA_W  forwarded EX operands
- ex_fwd_sel  output  NUM_SRC*2  per-operand select (debug/visibility)
- stall  output  1  hold PC and IF/ID, inject bubble into ID/EX
- flush_ifid  output  1  squash IF/ID contents
- flush_idex  output  1  insert bubble into ID/EX
- stall_cnt  output  32  stall cycles (see Configuration)
- flush_cnt  output  32  flush events (see Configuration)

## Operation
- Internal metadata shift chain EX→MEM→WB. Each entry holds valid, dst_addr, dst_we and is_load. EX additionally holds the src_addr/src_used copies.
- Every cycle MEM←EX and WB←MEM. EX←ID entry when stall=0 and flush_idex=0; otherwise EX←bubble (valid=0).
- An entry is a forwarding candidate only if valid && dst_we. When R0_ZERO=1 it also requires dst_addr≠0.
- Operand k forwarding, evaluated against the EX copy of src k:
  - If src_used[k] and a MEM candidate matches and MEM is not a load → FWD_MEM (mem_alu_data).
  - Else if a WB candidate matches → FWD_WB (wb_data).
  - Else → FWD_RF (ex_rf_data).
  - MEM has priority over WB, because MEM holds the newest producer.
- A MEM-stage load never forwards from MEM. The load-use stall guarantees it has reached WB before it is consumed.
- Load-use stall: stall=1 when id_valid && EX candidate && EX.is_load && EX.dst_addr equals any used ID source. Exactly one bubble per load-use pair.
- Branch flush: ex_branch_taken=1 → flush_ifid=1 and flush_idex=1 in the same cycle. Stall is forced to 0 when a flush occurs, because the stalled instruction is on the wrong path.
- Instructions with id_dst_we=0 (store, beq, j) never create hazards as producers.

## Timing
- stall, flush_* and ex_fwd_sel/ex_opnd are combinational from registered metadata plus current ID inputs, with no added latency.
- Metadata updates on the rising clc edge.
- Reset (reset=0, asynchronous):
  - All entries become valid=0.
  - stall=0, flush_ifid=0, flush_idex=0, ex_fwd_sel=0 (all FWD_RF), ex_opnd=ex_rf_data.
  - Counters are cleared to 0.
- Deasserting reset mid-stream restarts with an empty chain; no stale forwarding occurs.
- Back-to-back load-use pairs stall one cycle each.
- Consecutive stall cycles for the same pair cannot occur.

## Configuration
- HAZ_PERF_EN defined:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle flush_ifid=1.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
- HAZ_PERF_EN undefined: counters are not built and both ports are tied to 0.

## Structure
- Package hazard_pkg holds:
  - Select encodings FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - The stage-metadata struct (valid, dst_addr, dst_we, is_load).
- Sub-module hazard_fwd_mux holds one operand's compare-and-select. It is instantiated NUM_SRC times via generate.

## Test plan
- Forwarding from MEM: add r3←r1,r2 then sub r4←r3,r5. Expect ex_fwd_sel[1:0]=FWD_MEM, ex_opnd0=mem_alu_data, stall=0.
- Double producer: add r3, add r3, then or using r3. Expect FWD_MEM, not FWD_WB. With only one intervening instruction, expect FWD_WB=wb_data.
- Load-use stall: lw r6 then add r7←r6,r1. Expect stall=1 for exactly one cycle, EX bubble, then FWD_WB with wb_data=0x0000_00A5.
- R0_ZERO=1: add r0←r1,r2 followed by a use of r0. Expect FWD_RF and no stall. With R0_ZERO=0, expect FWD_MEM.
- Flush over stall: a load-use condition coincident with ex_branch_taken=1. Expect stall=0, flush_ifid=1, flush_idex=1, next EX entry invalid.
- HAZ_PERF_EN: three stalls and two flushes. Expect stall_cnt=3 and flush_cnt=2. Async reset mid-run clears both to 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select encodings, per-stage destination metadata and
// the forwarding-candidate helper shared by the hazard controller and its muxes.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Widest register address the metadata can carry; narrower REG_AW is zero-extended.
  localparam int unsigned META_AW = 16;

  typedef struct packed {
    logic               valid;
    logic [META_AW-1:0] dst_addr;
    logic               dst_we;
    logic               is_load;
  } stage_meta_t;

  localparam stage_meta_t META_BUBBLE = '{
    valid:    1'b0,
    dst_addr: {META_AW{1'b0}},
    dst_we:   1'b0,
    is_load:  1'b0
  };

  // A stage can feed a consumer only if it really writes a register; with a
  // hardwired zero register, writes to address 0 are discarded.
  function automatic logic fwd_candidate(input stage_meta_t m, input logic r0_zero);
    return m.valid & m.dst_we & ~(r0_zero & (m.dst_addr == {META_AW{1'b0}}));
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// hazard_fwd_mux: compare-and-select for one EX source operand.
// MEM wins over WB because it holds the newer producer; MEM loads never forward.
module hazard_fwd_mux
  import hazard_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int R0_ZERO = 1
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  stage_meta_t       mem_meta,
  input  stage_meta_t       wb_meta,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] opnd
);

  logic [META_AW-1:0] src_ext_s;
  logic               mem_hit_s;
  logic               wb_hit_s;
  logic               unused_ok_s;

  assign src_ext_s   = META_AW'(src_addr);
  assign mem_hit_s   = src_used && fwd_candidate(mem_meta, R0_ZERO != 0) &&
                       !mem_meta.is_load && (mem_meta.dst_addr == src_ext_s);
  assign wb_hit_s    = src_used && fwd_candidate(wb_meta, R0_ZERO != 0) &&
                       (wb_meta.dst_addr == src_ext_s);
  assign unused_ok_s = wb_meta.is_load;

  // Operand select: MEM, then WB, otherwise the register-file value.
  always_comb begin
    sel  = FWD_RF;
    opnd = rf_data;
    if (mem_hit_s) begin
      sel  = FWD_MEM;
      opnd = mem_data;
    end else if (wb_hit_s) begin
      sel  = FWD_WB;
      opnd = wb_data;
    end else begin
      sel  = FWD_RF;
      opnd = rf_data;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and per-operand EX forwarding
// for a five-stage pipeline. Optional perf counters built under HAZ_PERF_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                      clc,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_we,
  input  logic                      id_is_load,
  input  logic                      ex_branch_taken,
  input  logic [NUM_SRC*DATA_W-1:0] ex_rf_data,
  input  logic [DATA_W-1:0]         mem_alu_data,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [NUM_SRC*DATA_W-1:0] ex_opnd,
  output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
  output logic                      stall,
  output logic                      flush_ifid,
  output logic                      flush_idex,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  stage_meta_t               ex_meta_r;
  stage_meta_t               mem_meta_r;
  stage_meta_t               wb_meta_r;
  stage_meta_t               id_meta_s;
  logic [NUM_SRC*REG_AW-1:0] ex_src_addr_r;
  logic [NUM_SRC-1:0]        ex_src_used_r;
  logic [NUM_SRC-1:0]        src_match_s;
  logic                      load_use_s;
  logic                      stall_s;
  logic                      flush_s;

  assign id_meta_s = '{
    valid:    id_valid,
    dst_addr: META_AW'(id_dst_addr),
    dst_we:   id_dst_we,
    is_load:  id_is_load
  };

  // Which used ID sources name the register the EX-stage instruction writes.
  always_comb begin
    src_match_s = {NUM_SRC{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      src_match_s[k] = id_src_used[k] &&
                       (META_AW'(id_src_addr[k*REG_AW +: REG_AW]) == ex_meta_r.dst_addr);
    end
  end

  assign load_use_s = id_valid && fwd_candidate(ex_meta_r, R0_ZERO != 0) &&
                      ex_meta_r.is_load && (|src_match_s);
  assign flush_s    = ex_branch_taken;
  // The ID instruction is on the wrong path when a branch is taken, so it never stalls.
  assign stall_s    = load_use_s && !flush_s;

  assign stall      = stall_s;
  assign flush_ifid = flush_s;
  assign flush_idex = flush_s;

  // Metadata shift chain EX -> MEM -> WB; a stall or flush puts a bubble into EX.
  always_ff @(posedge clc or negedge reset) begin
    if (!reset) begin
      ex_meta_r     <= META_BUBBLE;
      mem_meta_r    <= META_BUBBLE;
      wb_meta_r     <= META_BUBBLE;
      ex_src_addr_r <= {(NUM_SRC*REG_AW){1'b0}};
      ex_src_used_r <= {NUM_SRC{1'b0}};
    end else begin
      mem_meta_r <= ex_meta_r;
      wb_meta_r  <= mem_meta_r;
      if (stall_s || flush_s) begin
        ex_meta_r     <= META_BUBBLE;
        ex_src_addr_r <= {(NUM_SRC*REG_AW){1'b0}};
        ex_src_used_r <= {NUM_SRC{1'b0}};
      end else begin
        ex_meta_r     <= id_meta_s;
        ex_src_addr_r <= id_src_addr;
        ex_src_used_r <= id_src_used & {NUM_SRC{id_valid}};
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    hazard_fwd_mux #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .R0_ZERO (R0_ZERO)
    ) u_fwd (
      .src_addr (ex_src_addr_r[k*REG_AW +: REG_AW]),
      .src_used (ex_src_used_r[k]),
      .mem_meta (mem_meta_r),
      .wb_meta  (wb_meta_r),
      .rf_data  (ex_rf_data[k*DATA_W +: DATA_W]),
      .mem_data (mem_alu_data),
      .wb_data  (wb_data),
      .sel      (ex_fwd_sel[k*2 +: 2]),
      .opnd     (ex_opnd[k*DATA_W +: DATA_W])
    );
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating counts of stall cycles and flush cycles.
  always_ff @(posedge clc or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, load-use stall, flush,
// the zero register (R0_ZERO=1 and a second R0_ZERO=0 instance) and reset.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] RF0  = 32'h1111_1111;
  localparam logic [31:0] RF1  = 32'h2222_2222;
  localparam logic [31:0] MEMD = 32'hAAAA_0001;
  localparam logic [31:0] WBD  = 32'hBBBB_0002;
  localparam logic [31:0] LDD  = 32'h0000_00A5;
`ifdef HAZ_PERF_EN
  localparam logic [63:0] EXP_STALL = 64'd3;
  localparam logic [63:0] EXP_FLUSH = 64'd2;
`else
  localparam logic [63:0] EXP_STALL = 64'd0;
  localparam logic [63:0] EXP_FLUSH = 64'd0;
`endif

  logic        clc;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [4:0]  id_dst_addr;
  logic        id_dst_we;
  logic        id_is_load;
  logic        ex_branch_taken;
  logic [63:0] ex_rf_data;
  logic [31:0] mem_alu_data;
  logic [31:0] wb_data;
  logic [63:0] ex_opnd, ex_opnd_nz;
  logic [3:0]  ex_fwd_sel, ex_fwd_sel_nz;
  logic        stall, stall_nz;
  logic        flush_ifid, flush_ifid_nz;
  logic        flush_idex, flush_idex_nz;
  logic [31:0] stall_cnt, stall_cnt_nz;
  logic [31:0] flush_cnt, flush_cnt_nz;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .R0_ZERO(1)) dut (
    .clc(clc), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .ex_rf_data(ex_rf_data),
    .mem_alu_data(mem_alu_data), .wb_data(wb_data), .ex_opnd(ex_opnd),
    .ex_fwd_sel(ex_fwd_sel), .stall(stall), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .R0_ZERO(0)) dut_nz (
    .clc(clc), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .ex_rf_data(ex_rf_data),
    .mem_alu_data(mem_alu_data), .wb_data(wb_data), .ex_opnd(ex_opnd_nz),
    .ex_fwd_sel(ex_fwd_sel_nz), .stall(stall_nz), .flush_ifid(flush_ifid_nz),
    .flush_idex(flush_idex_nz), .stall_cnt(stall_cnt_nz), .flush_cnt(flush_cnt_nz)
  );

  initial clc = 1'b0;
  always #5 clc = ~clc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input int v, input int s0, input int s1, input int used,
                        input int d, input int we, input int ld);
    id_valid    = 1'(v);
    id_src_addr = {5'(s1), 5'(s0)};
    id_src_used = 2'(used);
    id_dst_addr = 5'(d);
    id_dst_we   = 1'(we);
    id_is_load  = 1'(ld);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clc);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    ex_branch_taken = 1'b0;
    ex_rf_data      = {RF1, RF0};
    mem_alu_data    = MEMD;
    wb_data         = WBD;
    nop();
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'({flush_ifid, flush_idex}), 64'd0);
    chk("rst_sel", 64'(ex_fwd_sel), 64'd0);
    chk("rst_opnd", ex_opnd, {RF1, RF0});
    chk("rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    chk("rst_cnt_nz", 64'(stall_cnt_nz), 64'd0);
    @(negedge clc);
    reset = 1'b1;

    // add r3<-r1,r2 ; sub r4<-r3,r5 : MEM forward on operand 0
    tick(); set_id(1, 1, 2, 3, 3, 1, 0); #2;
    chk("A_issue_stall", 64'(stall), 64'd0);
    tick(); set_id(1, 3, 5, 3, 4, 1, 0); #2;
    chk("A_use_stall", 64'(stall), 64'd0);
    tick(); nop(); #2;
    chk("A_sel", 64'(ex_fwd_sel), 64'h1);
    chk("A_opnd", ex_opnd, {RF1, MEMD});
    tick(); nop(); #2;
    chk("A_drain_sel", 64'(ex_fwd_sel), 64'h0);

    // add r3 ; add r3 ; or r8<-r3,r9 : newest producer (MEM) wins
    tick(); set_id(1, 1, 2, 3, 3, 1, 0);
    tick(); set_id(1, 1, 2, 3, 3, 1, 0);
    tick(); set_id(1, 3, 9, 3, 8, 1, 0);
    tick(); nop(); #2;
    chk("B_dbl_sel", 64'(ex_fwd_sel), 64'h1);
    chk("B_dbl_opnd", ex_opnd, {RF1, MEMD});

    // add r3 ; add r10 ; or r8<-r9,r3 : WB forward on operand 1
    tick(); set_id(1, 1, 2, 3, 3, 1, 0);
    tick(); set_id(1, 11, 12, 3, 10, 1, 0);
    tick(); set_id(1, 9, 3, 3, 8, 1, 0);
    tick(); nop(); #2;
    chk("B_wb_sel", 64'(ex_fwd_sel), 64'h8);
    chk("B_wb_opnd", ex_opnd, {WBD, RF0});

    // lw r6 ; add r7<-r6,r1 : one bubble, then WB forward of load data
    tick(); set_id(1, 1, 0, 1, 6, 1, 1); #2;
    chk("C_lw_stall", 64'(stall), 64'd0);
    tick(); set_id(1, 6, 1, 3, 7, 1, 0); #2;
    chk("C_lu_stall", 64'(stall), 64'd1);
    chk("C_lu_flush", 64'(flush_ifid), 64'd0);
    tick(); #2;
    chk("C_one_bubble", 64'(stall), 64'd0);
    chk("C_bubble_sel", 64'(ex_fwd_sel), 64'h0);
    tick(); nop(); wb_data = LDD; #2;
    chk("C_wb_sel", 64'(ex_fwd_sel), 64'h2);
    chk("C_wb_opnd", ex_opnd, {RF1, LDD});
    chk("C_after_stall", 64'(stall), 64'd0);
    wb_data = WBD;

    // lw r6 ; lw r8<-r6 ; add r9<-r8,r2 : back-to-back pairs stall once each
    tick(); set_id(1, 1, 0, 1, 6, 1, 1);
    tick(); set_id(1, 6, 0, 1, 8, 1, 1); #2;
    chk("C2_stall1", 64'(stall), 64'd1);
    tick(); #2;
    chk("C2_release1", 64'(stall), 64'd0);
    tick(); set_id(1, 8, 2, 3, 9, 1, 0); #2;
    chk("C2_stall2", 64'(stall), 64'd1);
    tick(); #2;
    chk("C2_release2", 64'(stall), 64'd0);
    tick(); nop();

    // add r0<-r1,r2 ; add r11<-r0,r0 : zero register never forwards
    tick(); set_id(1, 1, 2, 3, 0, 1, 0);
    tick(); set_id(1, 0, 0, 3, 11, 1, 0); #2;
    chk("D_r0_stall", 64'(stall), 64'd0);
    tick(); nop(); #2;
    chk("D_r0_sel", 64'(ex_fwd_sel), 64'h0);
    chk("D_r0_opnd", ex_opnd, {RF1, RF0});
    chk("D_nz_sel", 64'(ex_fwd_sel_nz), 64'h5);
    chk("D_nz_opnd", ex_opnd_nz, {MEMD, MEMD});
    // lw r0 ; use r0 : stall only without the zero register
    tick(); set_id(1, 1, 0, 1, 0, 1, 1);
    tick(); set_id(1, 0, 1, 3, 11, 1, 0); #2;
    chk("D_r0_lu", 64'(stall), 64'd0);
    chk("D_nz_lu", 64'(stall_nz), 64'd1);
    tick(); nop();
    tick(); nop();
    tick(); nop();

    // lw r6 ; lw r13<-r6 with branch taken : flush overrides the stall
    tick(); set_id(1, 1, 0, 1, 6, 1, 1);
    tick(); set_id(1, 6, 0, 1, 13, 1, 1); ex_branch_taken = 1'b1; #2;
    chk("E_stall", 64'(stall), 64'd0);
    chk("E_flush_ifid", 64'(flush_ifid), 64'd1);
    chk("E_flush_idex", 64'(flush_idex), 64'd1);
    chk("E_nz_flush_idex", 64'(flush_idex_nz), 64'd1);
    tick(); ex_branch_taken = 1'b0; set_id(1, 13, 13, 3, 14, 1, 0); #2;
    chk("E_ex_invalid", 64'(stall), 64'd0);
    chk("E_ex_sel", 64'(ex_fwd_sel), 64'h0);
    tick(); nop(); ex_branch_taken = 1'b1; #2;
    chk("E_flush2", 64'(flush_ifid), 64'd1);
    tick(); ex_branch_taken = 1'b0; #2;
    chk("E_flush_off", 64'({flush_ifid, flush_idex}), 64'd0);
    chk("E_stall_cnt", 64'(stall_cnt), EXP_STALL);
    chk("E_flush_cnt", 64'(flush_cnt), EXP_FLUSH);

    // Async reset mid-stream wipes a live MEM producer and the counters
    tick(); set_id(1, 1, 2, 3, 3, 1, 0);
    tick(); set_id(1, 3, 5, 3, 4, 1, 0);
    tick(); nop(); #2;
    chk("F_pre_sel", 64'(ex_fwd_sel), 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("F_rst_sel", 64'(ex_fwd_sel), 64'h0);
    chk("F_rst_opnd", ex_opnd, {RF1, RF0});
    chk("F_rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    @(negedge clc);
    reset = 1'b1;
    set_id(1, 3, 5, 3, 4, 1, 0);
    tick(); nop(); #2;
    chk("F_no_stale", 64'(ex_fwd_sel), 64'h0);
    chk("F_no_stale_opnd", ex_opnd, {RF1, RF0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
